fu_store_buffer: RTL and testbench
==================================

Name:
fu_store_buffer

Overview:
- Store-side counterpart of the load functional unit (fu_mem). Accepts issued stores (SW/SB) from the reservation station and computes each address.
- Holds stores speculatively until the ROB retires them, then drains them in order to the data BRAM write port.
- Drops speculative stores on a branch mispredict.
- Exposes an address-conflict check so the load FU can stall loads that hit a pending store.

Parameters:
DEPTH, 8, number of store entries (power of 2, ≥2)
TAG_W, 5, ROB tag width (matches rob_index / curr_rob_tag)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
issued  in  1  store issued from RS this cycle
data_in  in  rs_data  issued op (Opcode, func3, imm, rob_index used)
ps1_data  in  32  base register value
ps2_data  in  32  store data register value
curr_rob_tag  in  TAG_W  ROB tail (next tag to allocate)
mispredict  in  1  flush request
mispredict_tag  in  TAG_W  tag of the mispredicted branch
retire_valid  in  1  ROB retiring a store this cycle
retire_tag  in  TAG_W  tag being retired
ld_addr  in  32  address of the load currently in fu_mem
sb_ready  out  1  buffer can accept an issue (count < DEPTH)
store_done  out  1  pulse: store address/data captured
store_done_tag  out  TAG_W  ROB tag for store_done
ld_conflict  out  1  a valid entry matches ld_addr word (addr[31:2])
mem_we  out  1  BRAM write strobe
mem_addr  out  32  BRAM byte address
mem_wdata  out  32  BRAM write data
mem_be  out  4  byte enables

Behaviour:
- Reset:
  - All entries invalid; head = tail = count = 0.
  - sb_ready = 1.
  - store_done, mem_we, ld_conflict = 0.
  - store_done_tag, mem_addr, mem_wdata, mem_be = 0.
  - Reset mid-drain discards all entries, including committed ones.
- Accept conditions:
  - An issue is accepted only when issued && sb_ready && Opcode == 7'b0100011.
  - Stores issue in program order (guaranteed by RS).
  - issued while !sb_ready is a protocol error; it is ignored.
- Allocation (on accepted issue, at posedge):
  - entry[tail] = {valid=1, committed=0, tag=rob_index, addr=ps1_data+imm (mod 2^32)}.
  - func3 = 010 (SW): wdata = ps2_data, be = 4'b1111.
  - func3 = 000 (SB): wdata = {4{ps2_data[7:0]}}, be = 4'b0001 << addr[1:0].
  - Any other func3: entry still allocated, with be = 0 (a no-op write).
  - tail advances, wrapping mod DEPTH.
- Completion: store_done = 1 for exactly one cycle, on the cycle after allocation, with store_done_tag = rob_index. Latency is 1.
- Commit:
  - When retire_valid and the oldest uncommitted valid entry has tag == retire_tag, mark it committed.
  - A retire_tag matching no such entry is ignored.
- Drain:
  - Each cycle the head entry is valid && committed: mem_we = 1 with that entry's addr/wdata/be (registered output, 1 cycle after the commit is visible).
  - The head entry is then invalidated, head++ and count--.
  - At most one write per cycle; the BRAM accepts a write every cycle.
- Mispredict (registered, same edge as other updates):
  - Define younger(t) = 0 < (t - mispredict_tag) mod 2^TAG_W < (curr_rob_tag - mispredict_tag) mod 2^TAG_W.
  - Every valid, uncommitted entry with younger(tag) is invalidated.
  - Tail is set to the index of the oldest flushed entry, and count is recomputed.
  - Committed entries are never flushed.
  - An issue in the same cycle whose rob_index is younger is not allocated, and no store_done is generated for it.
  - A pending store_done whose tag is younger is suppressed.
- Simultaneous events:
  - Issue, commit and drain in the same cycle are all honoured: count = count + alloc − drain.
  - sb_ready is computed from the registered count, so a full buffer draining this cycle still rejects that cycle's issue.
- Wrap-around: head/tail wrap mod DEPTH; full is count == DEPTH, empty is count == 0.
- ld_conflict: combinational. It is 1 if any valid entry has addr[31:2] == ld_addr[31:2]. Committed-but-undrained entries count as conflicts.

Decomposition:
- types_pkg additions:
  - sb_entry typedef: valid, committed, tag, addr, wdata, be.
  - OPC_STORE = 7'b0100011, F3_SW = 3'b010, F3_SB = 3'b000.
  - A shared function rob_younger(tag, mis_tag, tail_tag), reused by fu_mem/ROB.
- No sub-module: a single module holding the entry array and the head/tail control.

Test Plan:
- Reset, then SW base=0x100, imm=4, data=0xDEADBEEF, tag 1 → store_done=1 with tag 1 the next cycle; no mem_we until retire. Retire tag 1 → mem_we=1, addr=0x104, wdata=0xDEADBEEF, be=1111.
- SB base=0, imm=3, data=0x000000A5, tag 2, then retire → mem_we=1, addr=0x3, wdata=0xA5A5A5A5, be=1000.
- Issue 8 stores (tags 0–7) without retiring → sb_ready=0 after the 8th; a 9th issued is ignored. Retire tag 0 → one write, then sb_ready=1.
- Stores tags 4, 5, 6 with tag 4 retired; mispredict_tag=4, curr_rob_tag=8 → tags 5 and 6 dropped, tag 4 is still written, count=0 afterwards.
- Pending SW at 0x200 and ld_addr=0x202 → ld_conflict=1. ld_addr=0x204 → 0. After drain at 0x202 → 0.
- Tags 30, 31, 0 issued with tail wrap; mispredict_tag=30, curr_rob_tag=1 → tags 31 and 0 flushed, tag 30 kept.

Source files
------------

// File: rtl/fu_store_buffer_pkg.sv
// fu_store_buffer_pkg: shared types, opcodes and ROB age helper for the store buffer.
package fu_store_buffer_pkg;

    localparam int SB_TAG_W = 5;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_SW     = 3'b010;
    localparam logic [2:0] F3_SB     = 3'b000;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          func3;
        logic [31:0]         imm;
        logic [SB_TAG_W-1:0] rob_index;
    } rs_data;

    typedef struct packed {
        logic                valid;
        logic                committed;
        logic [SB_TAG_W-1:0] tag;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic [3:0]          be;
    } sb_entry;

    // True when tag was allocated after mis_tag and before the ROB tail.
    function automatic logic rob_younger(input logic [SB_TAG_W-1:0] tag,
                                         input logic [SB_TAG_W-1:0] mis_tag,
                                         input logic [SB_TAG_W-1:0] tail_tag);
        logic [SB_TAG_W-1:0] d;
        logic [SB_TAG_W-1:0] e;
        d = tag - mis_tag;
        e = tail_tag - mis_tag;
        return (d != '0) && (d < e);
    endfunction

endpackage

// File: rtl/fu_store_buffer.sv
// fu_store_buffer: holds issued stores until ROB retirement, drains them in order to BRAM,
// flushes speculative stores on mispredict and flags loads that alias a pending store.
module fu_store_buffer
    import fu_store_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = SB_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issued,
    input  rs_data           data_in,
    input  logic [31:0]      ps1_data,
    input  logic [31:0]      ps2_data,
    input  logic [TAG_W-1:0] curr_rob_tag,
    input  logic             mispredict,
    input  logic [TAG_W-1:0] mispredict_tag,
    input  logic             retire_valid,
    input  logic [TAG_W-1:0] retire_tag,
    input  logic [31:0]      ld_addr,
    output logic             sb_ready,
    output logic             store_done,
    output logic [TAG_W-1:0] store_done_tag,
    output logic             ld_conflict,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry          q [DEPTH];
    sb_entry          new_e;
    logic [PTR_W-1:0] head, tail, commit_idx, base_tail;
    logic [CNT_W-1:0] count, flush_off, base_cnt;
    logic [DEPTH-1:0] flush;
    logic [31:0]      new_addr;
    logic             alloc, drain, commit_hit, do_commit, flush_hit, done_q;
    logic [TAG_W-1:0] done_tag;
    logic             unused_ld;

    assign unused_ld      = ^ld_addr[1:0];
    assign sb_ready       = !count[PTR_W];
    assign store_done_tag = done_tag;
    assign store_done     = done_q && !(mispredict && rob_younger(done_tag, mispredict_tag, curr_rob_tag));

    always_comb begin
        new_addr        = ps1_data + data_in.imm;
        new_e.valid     = 1'b1;
        new_e.committed = 1'b0;
        new_e.tag       = data_in.rob_index;
        new_e.addr      = new_addr;
        new_e.wdata     = data_in.func3 == F3_SB ? {4{ps2_data[7:0]}} : ps2_data;
        new_e.be        = data_in.func3 == F3_SW ? 4'b1111 :
                          data_in.func3 == F3_SB ? 4'b0001 << new_addr[1:0] : 4'b0000;
        alloc = issued && sb_ready && data_in.opcode == OPC_STORE &&
                !(mispredict && rob_younger(data_in.rob_index, mispredict_tag, curr_rob_tag));
        drain       = q[head].valid && q[head].committed;
        ld_conflict = 1'b0;
        commit_hit  = 1'b0;
        commit_idx  = head;
        flush_hit   = 1'b0;
        flush_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            flush[i] = mispredict && q[i].valid && !q[i].committed &&
                       rob_younger(q[i].tag, mispredict_tag, curr_rob_tag);
            ld_conflict |= q[i].valid && q[i].addr[31:2] == ld_addr[31:2];
        end
        // Walk from head so the first hit is the oldest entry in program order.
        for (int i = 0; i < DEPTH; i++) begin
            if (!commit_hit && q[head + PTR_W'(i)].valid && !q[head + PTR_W'(i)].committed) begin
                commit_hit = 1'b1;
                commit_idx = head + PTR_W'(i);
            end
            if (!flush_hit && flush[head + PTR_W'(i)]) begin
                flush_hit = 1'b1;
                flush_off = CNT_W'(i);
            end
        end
        do_commit = retire_valid && commit_hit && q[commit_idx].tag == retire_tag;
        base_tail = flush_hit ? head + flush_off[PTR_W-1:0] : tail;
        base_cnt  = flush_hit ? flush_off : count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            done_q    <= 1'b0;
            done_tag  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            if (do_commit) q[commit_idx].committed <= 1'b1;
            for (int i = 0; i < DEPTH; i++) if (flush[i]) q[i].valid <= 1'b0;
            if (drain) q[head].valid <= 1'b0;
            if (alloc) q[base_tail] <= new_e;
            mem_we <= drain;
            if (drain) begin
                mem_addr  <= q[head].addr;
                mem_wdata <= q[head].wdata;
                mem_be    <= q[head].be;
            end
            head   <= head + PTR_W'(drain);
            tail   <= base_tail + PTR_W'(alloc);
            count  <= base_cnt + CNT_W'(alloc) - CNT_W'(drain);
            done_q <= alloc;
            if (alloc) done_tag <= data_in.rob_index;
        end
    end

endmodule

// File: tb/tb_fu_store_buffer.sv
// tb_fu_store_buffer: directed scoreboard bench for the store buffer.
module tb_fu_store_buffer;
    import fu_store_buffer_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset, issued, mispredict, retire_valid;
    rs_data      data_in;
    logic [31:0] ps1_data, ps2_data, ld_addr;
    logic [4:0]  curr_rob_tag, mispredict_tag, retire_tag;
    logic        sb_ready, store_done, ld_conflict, mem_we;
    logic [4:0]  store_done_tag;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int          total = 0;
    int          bad = 0;
    logic [4:0]  done_q [$];
    wr_t         wr_q [$];

    always #5 clk = ~clk;

    fu_store_buffer dut (
        .clk(clk), .reset(reset), .issued(issued), .data_in(data_in),
        .ps1_data(ps1_data), .ps2_data(ps2_data), .curr_rob_tag(curr_rob_tag),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .retire_valid(retire_valid), .retire_tag(retire_tag), .ld_addr(ld_addr),
        .sb_ready(sb_ready), .store_done(store_done), .store_done_tag(store_done_tag),
        .ld_conflict(ld_conflict), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; then every store_done / mem_we is matched against the scoreboard.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (store_done) begin
            if (done_q.size() == 0) chk("done_unexpected", 32'(store_done_tag), 32'hFFFF_FFFF);
            else chk("done_tag", 32'(store_done_tag), 32'(done_q.pop_front()));
        end
        if (done_q.size() != 0) begin
            chk("done_missing", 32'(done_q.size()), 0);
            done_q.delete();
        end
        if (mem_we) begin
            if (wr_q.size() == 0) chk("we_unexpected", mem_addr, 32'hFFFF_FFFF);
            else begin
                w = wr_q.pop_front();
                chk("wr_addr", mem_addr, w.a);
                chk("wr_data", mem_wdata, w.d);
                chk("wr_be", 32'(mem_be), 32'(w.b));
            end
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] data, input logic [4:0] tag, input bit acc);
        issued            = 1'b1;
        data_in.opcode    = OPC_STORE;
        data_in.func3     = f3;
        data_in.imm       = imm;
        data_in.rob_index = tag;
        ps1_data          = base;
        ps2_data          = data;
        if (acc) done_q.push_back(tag);
        tick();
        issued = 1'b0;
    endtask

    task automatic retire(input logic [4:0] tag, input bit exp, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        wr_t w;
        retire_valid = 1'b1;
        retire_tag   = tag;
        w.a = a;
        w.d = d;
        w.b = b;
        if (exp) wr_q.push_back(w);
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic conflict(input logic [31:0] a, input logic exp, input string tag);
        ld_addr = a;
        #1;
        chk(tag, 32'(ld_conflict), 32'(exp));
    endtask

    task automatic drained(input string tag);
        repeat (3) tick();
        chk(tag, 32'(wr_q.size()), 0);
    endtask

    initial begin
        reset = 1'b1; issued = 1'b0; mispredict = 1'b0; retire_valid = 1'b0;
        data_in = '0; ps1_data = '0; ps2_data = '0; ld_addr = 32'h0000_0FF0;
        curr_rob_tag = '0; mispredict_tag = '0; retire_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(sb_ready), 1);
        chk("rst_done", 32'(store_done), 0);
        chk("rst_done_tag", 32'(store_done_tag), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_conflict", 32'(ld_conflict), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", 32'(mem_be), 0);
        reset = 1'b0;
        tick();

        // SW, write only after retirement, one cycle after commit
        issue(F3_SW, 32'h100, 32'h4, 32'hDEADBEEF, 5'd1, 1);
        tick();
        chk("sw_no_we_before_retire", 32'(mem_we), 0);
        retire(5'd1, 1, 32'h104, 32'hDEADBEEF, 4'b1111);
        chk("sw_we_latency", 32'(mem_we), 0);
        tick();
        chk("sw_written", 32'(wr_q.size()), 0);

        // SB byte replication and lane enable
        issue(F3_SB, 32'h0, 32'h3, 32'h0000_00A5, 5'd2, 1);
        retire(5'd2, 1, 32'h3, 32'hA5A5A5A5, 4'b1000);
        drained("sb_written");

        // Fill to DEPTH, reject extra issue, stray retire ignored
        for (int i = 0; i < 8; i++) issue(F3_SW, 32'h1000, 32'(i * 4), 32'(i), 5'(i), 1);
        chk("full_not_ready", 32'(sb_ready), 0);
        issue(F3_SW, 32'h1000, 32'h20, 32'h8, 5'd8, 0);
        retire(5'd3, 0, 0, 0, 0);
        tick();
        retire(5'd0, 1, 32'h1000, 32'h0, 4'b1111);
        chk("commit_still_full", 32'(sb_ready), 0);
        tick();
        chk("drain_frees_slot", 32'(sb_ready), 1);
        for (int i = 1; i < 8; i++) retire(5'(i), 1, 32'h1000 + 32'(i * 4), 32'(i), 4'b1111);
        drained("fill_written");

        // Mispredict keeps committed tag 4, drops 5 and 6, blocks younger issue
        issue(F3_SW, 32'h2000, 32'h0, 32'h44, 5'd4, 1);
        issue(F3_SW, 32'h2000, 32'h4, 32'h55, 5'd5, 1);
        issue(F3_SW, 32'h2000, 32'h8, 32'h66, 5'd6, 1);
        retire(5'd4, 1, 32'h2000, 32'h44, 4'b1111);
        mispredict = 1'b1; mispredict_tag = 5'd4; curr_rob_tag = 5'd8;
        issue(F3_SW, 32'h2000, 32'hC, 32'h77, 5'd7, 0);
        mispredict = 1'b0;
        chk("flush_written", 32'(wr_q.size()), 0);
        conflict(32'h2004, 1'b0, "flushed5_conflict");
        conflict(32'h2008, 1'b0, "flushed6_conflict");
        conflict(32'h200C, 1'b0, "blocked7_conflict");
        retire(5'd5, 0, 0, 0, 0);
        drained("flushed_no_write");
        // count must be back to 0: exactly eight more fit
        for (int i = 0; i < 8; i++) begin
            chk("refill_ready", 32'(sb_ready), 1);
            issue(F3_SW, 32'h3000, 32'(i * 4), 32'(i), 5'(10 + i), 1);
        end
        chk("refill_full", 32'(sb_ready), 0);
        mispredict = 1'b1; mispredict_tag = 5'd9; curr_rob_tag = 5'd18;
        tick();
        mispredict = 1'b0;
        chk("flush_all_ready", 32'(sb_ready), 1);
        conflict(32'h3000, 1'b0, "flush_all_conflict");

        // Load conflict, including committed-but-undrained entry
        issue(F3_SW, 32'h200, 32'h0, 32'h1234_5678, 5'd20, 1);
        conflict(32'h202, 1'b1, "ld_same_word");
        conflict(32'h204, 1'b0, "ld_next_word");
        conflict(32'h1FC, 1'b0, "ld_prev_word");
        ld_addr = 32'h202;
        retire(5'd20, 1, 32'h200, 32'h1234_5678, 4'b1111);
        conflict(32'h202, 1'b1, "ld_committed");
        drained("ld_written");
        conflict(32'h202, 1'b0, "ld_after_drain");
        ld_addr = 32'h0000_0FF0;

        // Tag wrap: flush 31 and 0 against mispredict 30, pending done suppressed
        issue(F3_SW, 32'h300, 32'h0, 32'h30, 5'd30, 1);
        issue(F3_SW, 32'h300, 32'h4, 32'h31, 5'd31, 1);
        issued = 1'b1;
        data_in.rob_index = 5'd0;
        data_in.imm = 32'h8;
        ps2_data = 32'h0;
        @(posedge clk);
        #1;
        issued = 1'b0;
        mispredict = 1'b1; mispredict_tag = 5'd30; curr_rob_tag = 5'd1;
        #1;
        chk("wrap_done_suppressed", 32'(store_done), 0);
        tick();
        mispredict = 1'b0;
        conflict(32'h304, 1'b0, "wrap_flushed31");
        conflict(32'h308, 1'b0, "wrap_flushed0");
        conflict(32'h300, 1'b1, "wrap_kept30");
        ld_addr = 32'h0000_0FF0;
        retire(5'd30, 1, 32'h300, 32'h30, 4'b1111);
        drained("wrap_written");
        retire(5'd31, 0, 0, 0, 0);
        drained("wrap_no_extra");

        chk("final_done_q", 32'(done_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
